// File: rtl/xheep_load_bridge_cu.sv
// FPGA-domain loader controller: synchronises USB-side valid flags, writes instructions
// into X-HEEP memory over req/gnt and returns level clear requests. Option: XHEEP_LOADER_AUTOINC_EN.
module xheep_load_bridge_cu #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  fpga_clk,
    input  logic                  rst_n,
    input  logic                  new_addr_valid_i,
    input  logic                  instr_valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  rst_new_addr_valid_o,
    output logic                  rst_instr_valid_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    output logic [15:0]           instr_count_o
);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        CAP_ADDR  = 5'b00010,
        ACK_ADDR  = 5'b00100,
        MEM_REQ   = 5'b01000,
        ACK_INSTR = 5'b10000
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [SYNC_STAGES-1:0]  addr_sync_r;
    logic [SYNC_STAGES-1:0]  instr_sync_r;
    logic                    addr_v_s;
    logic                    instr_v_s;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [15:0]             count_r;
    logic                    mem_req_r;
    logic                    rst_addr_r;
    logic                    rst_instr_r;
    logic                    grant_s;

    // Plain flop chains bring the USB-domain level flags into fpga_clk
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_sync_r  <= '0;
            instr_sync_r <= '0;
        end else begin
            addr_sync_r  <= {addr_sync_r[SYNC_STAGES-2:0], new_addr_valid_i};
            instr_sync_r <= {instr_sync_r[SYNC_STAGES-2:0], instr_valid_i};
        end
    end

    assign addr_v_s  = addr_sync_r[SYNC_STAGES-1];
    assign instr_v_s = instr_sync_r[SYNC_STAGES-1];
    assign grant_s   = (state_r == MEM_REQ) && mem_gnt_i;

    // Next-state decode; address flag wins over instruction flag in IDLE
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (addr_v_s) begin
                    next_state_s = CAP_ADDR;
                end else if (instr_v_s) begin
                    next_state_s = MEM_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CAP_ADDR:  next_state_s = ACK_ADDR;
            ACK_ADDR:  next_state_s = addr_v_s  ? ACK_ADDR  : IDLE;
            MEM_REQ:   next_state_s = mem_gnt_i ? ACK_INSTR : MEM_REQ;
            ACK_INSTR: next_state_s = instr_v_s ? ACK_INSTR : IDLE;
            default:   next_state_s = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they line up with it
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            rst_addr_r  <= 1'b1;
            rst_instr_r <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            mem_req_r   <= (next_state_s == MEM_REQ);
            rst_addr_r  <= (next_state_s != ACK_ADDR);
            rst_instr_r <= (next_state_s != ACK_INSTR);
        end
    end

    // Address/data capture and completed-write counter
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            count_r <= 16'd0;
        end else begin
            if ((state_r == IDLE) && !addr_v_s && instr_v_s) begin
                wdata_q <= instr_i;
            end else begin
                wdata_q <= wdata_q;
            end
            if (state_r == CAP_ADDR) begin
                addr_q  <= addr_i;
                count_r <= 16'd0;
            end else if (grant_s) begin
                count_r <= (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
`ifdef XHEEP_LOADER_AUTOINC_EN
                addr_q  <= addr_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
`else
                addr_q  <= addr_q;
`endif
            end else begin
                addr_q  <= addr_q;
                count_r <= count_r;
            end
        end
    end

    assign rst_new_addr_valid_o = rst_addr_r;
    assign rst_instr_valid_o    = rst_instr_r;
    assign mem_req_o            = mem_req_r;
    assign mem_we_o             = mem_req_r;
    assign mem_addr_o           = addr_q;
    assign mem_wdata_o          = wdata_q;
    assign instr_count_o        = count_r;

endmodule

// File: tb/tb_xheep_load_bridge_cu.sv
// Self-checking bench for xheep_load_bridge_cu: latency sequences, a vector table and
// randomized transactions against a transaction-level model (honours XHEEP_LOADER_AUTOINC_EN).
module tb_xheep_load_bridge_cu;

`ifdef XHEEP_LOADER_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        new_addr_valid_i;
    logic        instr_valid_i;
    logic [31:0] addr_i;
    logic [31:0] instr_i;
    logic        rst_new_addr_valid_o;
    logic        rst_instr_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic [15:0] instr_count_o;

    int total = 0;
    int bad   = 0;

    xheep_load_bridge_cu #(.SYNC_STAGES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .fpga_clk             (clk),
        .rst_n                (rst_n),
        .new_addr_valid_i     (new_addr_valid_i),
        .instr_valid_i        (instr_valid_i),
        .addr_i               (addr_i),
        .instr_i              (instr_i),
        .rst_new_addr_valid_o (rst_new_addr_valid_o),
        .rst_instr_valid_o    (rst_instr_valid_o),
        .mem_req_o            (mem_req_o),
        .mem_we_o             (mem_we_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_gnt_i            (mem_gnt_i),
        .instr_count_o        (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load_addr(input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        addr_i = a;
        new_addr_valid_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!rst_new_addr_valid_o) seen = 1'b1;
        end
        chk("addr_ack", seen, 1);
        new_addr_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rst_new_addr_valid_o) seen = 1'b1;
        end
        chk("addr_release", seen, 1);
    endtask

    task automatic do_instr(input logic [31:0] d, input int stall,
                            output logic [31:0] waddr, output logic [31:0] wdata, output int held);
        bit seen;
        seen = 1'b0;
        held = 0;
        waddr = 32'd0;
        wdata = 32'd0;
        instr_i = d;
        instr_valid_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_o) seen = 1'b1;
        end
        chk("req_seen", seen, 1);
        if (seen) begin
            waddr = mem_addr_o;
            wdata = mem_wdata_o;
            held  = 1;
            chk("we_eq_req", mem_we_o, 1);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (mem_req_o && mem_addr_o == waddr && mem_wdata_o == wdata) held++;
            end
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0;
            chk("req_drop", mem_req_o, 0);
            chk("instr_ack", rst_instr_valid_o, 0);
        end
        instr_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rst_instr_valid_o) seen = 1'b1;
        end
        chk("instr_release", seen, 1);
    endtask

    typedef struct {
        bit          is_addr;
        logic [31:0] val;
        int          stall;
        logic [31:0] exp_addr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] wa, wd, addr_m, a, d;
        logic [15:0] cnt_m;
        int held, lat, lat2, st;
        bit early;

        vecs[0] = '{1'b1, 32'h0000_1000, 0, 32'h0, 16'd0};
        vecs[1] = '{1'b0, 32'h0000_0013, 5, 32'h0000_1000, 16'd1};
        vecs[2] = '{1'b0, 32'h0000_0093, 0, AI ? 32'h0000_1004 : 32'h0000_1000, 16'd2};
        vecs[3] = '{1'b0, 32'h0000_0113, 2, AI ? 32'h0000_1008 : 32'h0000_1000, 16'd3};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 0, 32'h0, 16'd0};
        vecs[5] = '{1'b0, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFC, 16'd1};
        vecs[6] = '{1'b0, 32'h1234_5678, 0, AI ? 32'h0000_0000 : 32'hFFFF_FFFC, 16'd2};

        rst_n = 1'b0;
        new_addr_valid_i = 1'b0;
        instr_valid_i = 1'b0;
        addr_i = 32'd0;
        instr_i = 32'd0;
        mem_gnt_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_clr_addr", rst_new_addr_valid_o, 1);
        chk("rst_clr_instr", rst_instr_valid_o, 1);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_count", instr_count_o, 0);

        // Address handshake latency: low after 4 edges, high 3 edges after the drop
        addr_i = 32'h0000_1000;
        new_addr_valid_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (!rst_new_addr_valid_o) lat = i;
        end
        chk("addr_ack_latency", lat, 4);
        new_addr_valid_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (rst_new_addr_valid_o) lat = i;
        end
        chk("addr_release_latency", lat, 3);

        // Instruction latency with grant already high
        instr_i = 32'h0000_0013;
        instr_valid_i = 1'b1;
        mem_gnt_i = 1'b1;
        lat = 0;
        lat2 = 0;
        for (int i = 1; i <= 12 && lat2 == 0; i++) begin
            @(negedge clk);
            if (mem_req_o && lat == 0) lat = i;
            if (!rst_instr_valid_o) lat2 = i;
        end
        chk("req_latency", lat, 3);
        chk("instr_ack_latency", lat2, 4);
        chk("lat_count", instr_count_o, 1);
        instr_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        // Grant in IDLE is ignored
        chk("idle_gnt_req", mem_req_o, 0);
        chk("idle_gnt_count", instr_count_o, 1);
        mem_gnt_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_addr) begin
                load_addr(vecs[i].val);
                chk("vec_count_clear", instr_count_o, 0);
            end else begin
                do_instr(vecs[i].val, vecs[i].stall, wa, wd, held);
                chk("vec_addr", wa, vecs[i].exp_addr);
                chk("vec_data", wd, vecs[i].val);
                chk("vec_held", held, vecs[i].stall + 1);
                chk("vec_count", instr_count_o, vecs[i].exp_cnt);
            end
        end

        // Both flags together: address acknowledged before any write
        addr_i = 32'h0000_2000;
        instr_i = 32'hA5A5_0001;
        new_addr_valid_i = 1'b1;
        instr_valid_i = 1'b1;
        early = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (mem_req_o) early = 1'b1;
            if (!rst_new_addr_valid_o) lat = i;
        end
        chk("simul_addr_first", lat, 4);
        chk("simul_no_early_req", early, 0);
        new_addr_valid_i = 1'b0;
        do_instr(32'hA5A5_0001, 1, wa, wd, held);
        chk("simul_addr", wa, 32'h0000_2000);
        chk("simul_data", wd, 32'hA5A5_0001);
        chk("simul_count", instr_count_o, 1);

        // Reset while a write is pending
        load_addr(32'h0000_3000);
        instr_i = 32'h0000_0777;
        instr_valid_i = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 20 && !early; i++) begin
            @(negedge clk);
            if (mem_req_o) early = 1'b1;
        end
        chk("midrst_req_seen", early, 1);
        rst_n = 1'b0;
        instr_valid_i = 1'b0;
        #1;
        chk("midrst_req", mem_req_o, 0);
        chk("midrst_clr_addr", rst_new_addr_valid_o, 1);
        chk("midrst_clr_instr", rst_instr_valid_o, 1);
        chk("midrst_count", instr_count_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized transactions against a transaction-level model
        addr_m = 32'd0;
        cnt_m = 16'd0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                load_addr(a);
                addr_m = a;
                cnt_m = 16'd0;
                chk("rnd_count_clear", instr_count_o, cnt_m);
            end else begin
                d = $urandom;
                st = $urandom_range(0, 3);
                do_instr(d, st, wa, wd, held);
                if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                chk("rnd_addr", wa, addr_m);
                chk("rnd_data", wd, d);
                chk("rnd_held", held, st + 1);
                chk("rnd_count", instr_count_o, cnt_m);
                if (AI) addr_m = addr_m + 32'd4;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xheep_load_bridge_cu.md
# xheep_load_bridge_cu

FPGA-clock-domain loader controller between the USB-side status registers and X-HEEP memory. It synchronises the USB-domain `new_addr_valid` and `instr_valid` level flags and captures the address/instruction words. It writes each instruction into X-HEEP through a req/gnt write port, then returns active-low clear requests that the USB-domain handshake control unit turns into register clears. Together with that unit it forms a 4-phase, level-based cross-domain handshake.

## Interface
- `SYNC_STAGES`, 2, flip-flop depth of each flag synchroniser; legal range 2–4.
- `ADDR_WIDTH`, 32, address register and `mem_addr_o` width.
- `DATA_WIDTH`, 32, instruction and `mem_wdata_o` width.
- `fpga_clk`  in  1  FPGA-domain clock, 5–160 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `new_addr_valid_i`  in  1  USB-domain flag, asynchronous to `fpga_clk`; synchronised internally.
- `instr_valid_i`  in  1  USB-domain flag, asynchronous; synchronised internally.
- `addr_i`  in  ADDR_WIDTH  start address; quasi-static, stable from before `new_addr_valid_i` rises until it falls.
- `instr_i`  in  DATA_WIDTH  instruction word; quasi-static under the same rule with `instr_valid_i`.
- `rst_new_addr_valid_o`  out  1  active-low clear request for the address flag.
- `rst_instr_valid_o`  out  1  active-low clear request for the instruction flag.
- `mem_req_o`  out  1  write request to X-HEEP.
- `mem_we_o`  out  1  write enable; equals `mem_req_o`.
- `mem_addr_o`  out  ADDR_WIDTH  write address.
- `mem_wdata_o`  out  DATA_WIDTH  write data.
- `mem_gnt_i`  in  1  grant; one cycle completes the transfer.
- `instr_count_o`  out  16  number of completed instruction writes.

## Operation
- Each flag passes through its own `SYNC_STAGES` chain. Only the last stage (`addr_v_s`, `instr_v_s`) is used; no logic sits between stages.
- FSM, one-hot encoding: IDLE, CAP_ADDR, ACK_ADDR, MEM_REQ, ACK_INSTR.
  - IDLE: if `addr_v_s`, go to CAP_ADDR. Otherwise, if `instr_v_s`, go to MEM_REQ and load `wdata_q <= instr_i`. Otherwise stay. The address flag has priority.
  - CAP_ADDR: load `addr_q <= addr_i` and clear `instr_count_o` to 0, then go to ACK_ADDR.
  - ACK_ADDR: `rst_new_addr_valid_o = 0`. Stay while `addr_v_s` = 1; go to IDLE when it is 0.
  - MEM_REQ: `mem_req_o = mem_we_o = 1`, `mem_addr_o = addr_q`, `mem_wdata_o = wdata_q`. Hold until `mem_gnt_i` = 1. On the grant edge, increment `instr_count_o` (saturates at 0xFFFF) and go to ACK_INSTR.
  - ACK_INSTR: `rst_instr_valid_o = 0`. Stay while `instr_v_s` = 1; go to IDLE when it is 0.
  - Illegal or unreachable encoding: go to IDLE.
- Clear requests are held low for the whole ACK state, not pulsed. The USB unit waits for this output to return high before it re-arms.
- In every state other than MEM_REQ: `mem_req_o = mem_we_o = 0`. `mem_addr_o` and `mem_wdata_o` keep showing `addr_q` and `wdata_q`.
- Address arithmetic: unsigned, modulo 2^ADDR_WIDTH. `addr_q + 4` at `{ADDR_WIDTH{1'b1}} - 3` wraps to 0.

## Timing
- Reset values:
  - state IDLE
  - synchroniser flops 0
  - `addr_q` 0, `wdata_q` 0, `instr_count_o` 0
  - `rst_*_o` = 1
  - `mem_req_o` = `mem_we_o` = 0
  - `mem_addr_o` = 0, `mem_wdata_o` = 0
- Reset asserted mid-operation: everything returns to reset values immediately. A write in progress is abandoned. A clear request in progress is released (goes high).
- Flag rise at edge 0, meeting setup: `addr_v_s` = 1 after edge `SYNC_STAGES`; CAP_ADDR at `SYNC_STAGES+1`; `rst_new_addr_valid_o` = 0 after `SYNC_STAGES+2`.
- Instruction path: MEM_REQ after edge `SYNC_STAGES+1`. With `mem_gnt_i` already high, ACK_INSTR after `SYNC_STAGES+2`.
- A flag fall reaches the synchroniser output after `SYNC_STAGES` edges; the FSM returns to IDLE on the following edge.
- Both flags rising at once: address first (CAP_ADDR → ACK_ADDR → IDLE), then the instruction at the new `addr_q`.
- `mem_gnt_i` while not in MEM_REQ: ignored.

## Configuration
- `XHEEP_LOADER_AUTOINC_EN` defined: on each grant, `addr_q <= addr_q + 4`, so consecutive instructions land in consecutive words.
- `XHEEP_LOADER_AUTOINC_EN` undefined: `addr_q` changes only in CAP_ADDR. Each instruction requires a new address.

## Test plan
- Reset: `rst_n` = 0 mid-MEM_REQ → next sample shows `mem_req_o` = 0, `rst_*_o` = 1, `instr_count_o` = 0.
- Address load: `addr_i` = 0x0000_1000, raise `new_addr_valid_i` → `rst_new_addr_valid_o` low after 4 edges (SYNC_STAGES = 2). Drop the flag → output high again 3 edges later.
- Instruction write: `instr_i` = 0x0000_0013, `mem_gnt_i` stalled 5 cycles → `mem_req_o` held 6 cycles at `mem_addr_o` = 0x1000, `mem_wdata_o` = 0x13. Then `rst_instr_valid_o` low and `instr_count_o` = 1.
- Auto-increment with macro on: three instructions → writes at 0x1000, 0x1004, 0x1008. With macro off, all three at 0x1000.
- Wrap: address 0xFFFF_FFFC, two instructions (macro on) → writes at 0xFFFF_FFFC then 0x0000_0000.
- Simultaneous flags: both rise on the same edge with `addr_i` = 0x2000 → address acknowledged first, then the instruction written at 0x2000.
